tm1637_update_sequencer: RTL and testbench
==========================================

// Module: tm1637_update_sequencer
// PURPOSE
//  Controller that sequences one complete TM1637 display refresh through the DIO-mode byte engine.
//  Each refresh is three bus frames: data command 0x40; address 0xC0 plus 4 segment bytes; display control 0x88|bright or 0x80.
//  Sits between the user/ROM layer (update requests) and the byte engine (spi_master in DIO mode); owns framing, NACK retry and inter-frame gaps.
// PARAMETERS
//  DIGITS      4    segment bytes per refresh (1..6; address byte always 0xC0)
//  GAP_CYCLES  4    idle clk cycles between frames (>=1); counter width $clog2(GAP_CYCLES+1)
//  MAX_RETRY   2    frame re-sends after NACK before abort (0 = no retry)
// PORTS
//  clk          in   1          block clock (clk_led domain)
//  rst          in   1          synchronous, active-high reset
//  update_req   in   1          1-cycle pulse: request refresh
//  seg_data     in   8*DIGITS   segment bytes; byte 0 = [7:0] = leftmost digit
//  bright       in   3          brightness 0..7
//  disp_on      in   1          1 = display on (ctrl 0x88|bright), 0 = off (0x80)
//  eng_start    out  1          1-cycle pulse: engine sends eng_byte
//  eng_byte     out  8          byte to send (engine shifts LSB first)
//  eng_first    out  1          engine issues START before this byte
//  eng_last     out  1          engine issues STOP after this byte
//  eng_done     in   1          1-cycle pulse: byte + ACK slot complete
//  eng_ack      in   1          valid with eng_done; 1 = TM1637 pulled DIO low (ACK)
//  busy         out  1          refresh in progress
//  done         out  1          1-cycle pulse: refresh completed OK
//  nack_err     out  1          1-cycle pulse: refresh aborted after retries
// BEHAVIOUR
//  Reset: state IDLE; eng_start, eng_first, eng_last, busy, done, nack_err = 0; eng_byte = 8'h00; pending, retry_cnt, idx cleared.
//  Snapshot: in IDLE, accepting a request copies seg_data/bright/disp_on into shadow regs; inputs are ignored afterwards until next accept.
//  Pending: update_req while busy sets a 1-deep pending flag (further reqs merge); on return to IDLE a pending flag starts a new refresh next cycle with a fresh snapshot.
//  States: IDLE -> F0 -> GAP -> F1 -> GAP -> F2 -> IDLE.
//   F0: one byte 0x40, first=1, last=1.
//   F1: 0xC0 (first=1, last=0), then DIGITS shadow bytes; last byte has last=1.
//   F2: ctrl byte disp_on ? {5'b10001,bright} : 8'h80, first=1, last=1.
//   GAP: count GAP_CYCLES clk cycles, then advance to next frame; retries also pass through GAP.
//  Byte handshake: eng_start high exactly 1 cycle with eng_byte/eng_first/eng_last valid that cycle and held stable until eng_done.
//   Next eng_start no earlier than the cycle after eng_done. eng_done while no byte is outstanding is ignored.
//  Latency: request accept (IDLE, update_req=1) -> first eng_start on next cycle; busy rises same edge as accept.
//  NACK: eng_done with eng_ack=0 on any byte -> remaining bytes of frame skipped.
//   If retry_cnt < MAX_RETRY: retry_cnt++, GAP, resend whole frame from its first byte.
//   Else: nack_err pulse, busy=0, IDLE (pending flag kept).
//   retry_cnt clears at the start of each frame; it is per frame.
//  Completion: eng_done with ack=1 on F2 byte -> done pulse and busy=0 on same edge; state IDLE.
//  Simultaneous: update_req in the done/nack_err cycle sets pending (not lost). done and nack_err are never high together.
//  Reset mid-refresh: all state cleared next edge; no further eng_start.
//   Engine is reset by the same rst; no STOP is issued by this block.
//  Widths: byte index width $clog2(DIGITS+2); no wrap: index saturates at frame end by state change.
// STRUCTURE
//  Shared package (tm1637_pkg.vh): TM1637_CMD_DATA=8'h40, TM1637_CMD_ADDR=8'hC0, TM1637_CMD_CTRL_ON=5'b10001,
//   TM1637_CMD_CTRL_OFF=8'h80, state encodings.
//  Single module; the GAP counter is inline. The byte engine (spi_master, DIO mode) is instantiated by the parent, not inside.
// TESTING (bench models engine: eng_done 10 cycles after eng_start, eng_ack programmable)
//  seg_data=32'h4F5B063F, bright=3, disp_on=1, one update_req
//   -> bytes 40 | C0 3F 06 5B 4F | 8B; first/last flags per frame; >=4 idle cycles between frames; one done pulse.
//  disp_on=0 -> last byte 80; bright ignored.
//  NACK on first attempt of C0, ACK thereafter (MAX_RETRY=2) -> F1 resent once from C0, then done; no nack_err.
//  ACK forced 0 always -> 40 sent 3 times, then nack_err pulse, busy=0, no F1/F2 bytes.
//  Three update_req pulses during busy, seg_data changed mid-refresh
//   -> first refresh uses accept-time data; exactly one more refresh follows with new data; 2 done pulses total.
//  rst asserted during F1 digit 2 -> next cycle all outputs at reset values; no eng_start until new update_req.

Source files
------------

// File: rtl/tm1637_update_sequencer_pkg.sv
// TM1637 refresh sequencer: shared command bytes and state encodings.
// Imported by the sequencer top.
package tm1637_update_sequencer_pkg;

  localparam logic [7:0] TM1637_CMD_DATA     = 8'h40;
  localparam logic [7:0] TM1637_CMD_ADDR     = 8'hC0;
  localparam logic [4:0] TM1637_CMD_CTRL_ON  = 5'b10001;
  localparam logic [7:0] TM1637_CMD_CTRL_OFF = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_F0,
    ST_F1,
    ST_F2,
    ST_GAP
  } state_t;

  function automatic logic [7:0] ctrl_byte(
    input logic       on,
    input logic [2:0] br
  );
    return on ? {TM1637_CMD_CTRL_ON, br} : TM1637_CMD_CTRL_OFF;
  endfunction

endpackage

// File: rtl/tm1637_update_sequencer.sv
// TM1637 refresh sequencer: three bus frames per refresh,
// per-frame NACK retry, inter-frame gaps, 1-deep request pending.
module tm1637_update_sequencer
  import tm1637_update_sequencer_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int GAP_CYCLES = 4,
  parameter int MAX_RETRY  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  update_req,
  input  logic [8*DIGITS-1:0]   seg_data,
  input  logic [2:0]            bright,
  input  logic                  disp_on,
  output logic                  eng_start,
  output logic [7:0]            eng_byte,
  output logic                  eng_first,
  output logic                  eng_last,
  input  logic                  eng_done,
  input  logic                  eng_ack,
  output logic                  busy,
  output logic                  done,
  output logic                  nack_err
);

  localparam int IW = $clog2(DIGITS + 2);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_t              state_q, state_d;
  state_t              resume_q, resume_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [RW-1:0]       retry_q, retry_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic                pend_q, pend_d;
  logic [8*DIGITS-1:0] seg_q, seg_d;
  logic [2:0]          bright_q, bright_d;
  logic                on_q, on_d;
  logic                start_q, start_d;
  logic [7:0]          byte_q, byte_d;
  logic                first_q, first_d;
  logic                last_q, last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                nack_q, nack_d;

  logic                issue;
  state_t              iss_f;
  logic [IW-1:0]       iss_i;

  // Returns {first, last, byte} for byte i of frame f.
  function automatic logic [9:0] frame_byte(
    input state_t              f,
    input logic [IW-1:0]       i,
    input logic [8*DIGITS-1:0] seg,
    input logic                on,
    input logic [2:0]          br
  );
    logic [7:0] dig;
    dig = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (i == IW'(k + 1)) dig = seg[8*k +: 8];
    end
    case (f)
      ST_F0:   return {2'b11, TM1637_CMD_DATA};
      ST_F1: begin
        if (i == '0) return {2'b10, TM1637_CMD_ADDR};
        return {1'b0, (i == IW'(DIGITS)), dig};
      end
      ST_F2:   return {2'b11, ctrl_byte(on, br)};
      default: return '0;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    idx_d    = idx_q;
    retry_d  = retry_q;
    gap_d    = gap_q;
    pend_d   = pend_q;
    seg_d    = seg_q;
    bright_d = bright_q;
    on_d     = on_q;
    start_d  = 1'b0;
    byte_d   = byte_q;
    first_d  = first_q;
    last_d   = last_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    nack_d   = 1'b0;
    issue    = 1'b0;
    iss_f    = ST_F0;
    iss_i    = '0;

    if (update_req && state_q != ST_IDLE) pend_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (update_req || pend_q) begin
          pend_d   = 1'b0;
          seg_d    = seg_data;
          bright_d = bright;
          on_d     = disp_on;
          busy_d   = 1'b1;
          retry_d  = '0;
          issue    = 1'b1;
          iss_f    = ST_F0;
        end
      end
      ST_F0, ST_F1, ST_F2: begin
        if (eng_done) begin
          if (!eng_ack) begin
            if (retry_q < RW'(MAX_RETRY)) begin
              retry_d  = retry_q + RW'(1);
              resume_d = state_q;
              gap_d    = '0;
              state_d  = ST_GAP;
            end else begin
              nack_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end else if (!last_q) begin
            issue = 1'b1;
            iss_f = ST_F1;
            iss_i = idx_q + IW'(1);
          end else if (state_q == ST_F2) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            // New frame: retry budget is per frame.
            retry_d  = '0;
            resume_d = (state_q == ST_F0) ? ST_F1 : ST_F2;
            gap_d    = '0;
            state_d  = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          issue = 1'b1;
          iss_f = resume_q;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (issue) begin
      state_d = iss_f;
      idx_d   = iss_i;
      start_d = 1'b1;
      {first_d, last_d, byte_d} =
        frame_byte(iss_f, iss_i, seg_d, on_d, bright_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      resume_q <= ST_IDLE;
      idx_q    <= '0;
      retry_q  <= '0;
      gap_q    <= '0;
      pend_q   <= 1'b0;
      seg_q    <= '0;
      bright_q <= '0;
      on_q     <= 1'b0;
      start_q  <= 1'b0;
      byte_q   <= 8'h00;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      nack_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      idx_q    <= idx_d;
      retry_q  <= retry_d;
      gap_q    <= gap_d;
      pend_q   <= pend_d;
      seg_q    <= seg_d;
      bright_q <= bright_d;
      on_q     <= on_d;
      start_q  <= start_d;
      byte_q   <= byte_d;
      first_q  <= first_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      nack_q   <= nack_d;
    end
  end

  assign eng_start = start_q;
  assign eng_byte  = byte_q;
  assign eng_first = first_q;
  assign eng_last  = last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign nack_err  = nack_q;

endmodule

// File: tb/tb_tm1637_update_sequencer.sv
// Directed bench for tm1637_update_sequencer with a
// behavioural byte engine (done 10 cycles after start).
module tb_tm1637_update_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        update_req;
  logic [31:0] seg_data;
  logic [2:0]  bright;
  logic        disp_on;
  logic        eng_start;
  logic [7:0]  eng_byte;
  logic        eng_first;
  logic        eng_last;
  logic        eng_done = 1'b0;
  logic        eng_ack = 1'b0;
  logic        busy;
  logic        done;
  logic        nack_err;

  tm1637_update_sequencer #(
    .DIGITS(4), .GAP_CYCLES(4), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .rst(rst), .update_req(update_req),
    .seg_data(seg_data), .bright(bright), .disp_on(disp_on),
    .eng_start(eng_start), .eng_byte(eng_byte),
    .eng_first(eng_first), .eng_last(eng_last),
    .eng_done(eng_done), .eng_ack(eng_ack),
    .busy(busy), .done(done), .nack_err(nack_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // engine model state
  int         mode = 0;
  int         cyc = 0;
  int         cnt = 0;
  bit         outst = 0;
  logic       pend_ack = 1'b1;
  int         last_done = 0;
  int         c0_seen = 0;
  int         nb = 0;
  logic [9:0] log_q [256];
  int         done_cnt = 0;
  int         nack_cnt = 0;
  int         both_cnt = 0;
  int         gap_bad = 0;

  always @(negedge clk) begin
    cyc++;
    if (done) done_cnt++;
    if (nack_err) nack_cnt++;
    if (done && nack_err) both_cnt++;
    if (rst) begin
      eng_done = 1'b0;
      eng_ack  = 1'b0;
      outst    = 0;
      cnt      = 0;
    end else begin
      eng_done = 1'b0;
      if (outst) begin
        cnt--;
        if (cnt == 0) begin
          eng_done  = 1'b1;
          eng_ack   = pend_ack;
          outst     = 0;
          last_done = cyc;
        end
      end
      if (eng_start) begin
        if (nb < 256) log_q[nb] = {eng_first, eng_last, eng_byte};
        nb++;
        if (eng_first && eng_byte != 8'h40 && cyc - last_done < 5)
          gap_bad++;
        if (mode == 0) pend_ack = 1'b1;
        else if (mode == 1) pend_ack = 1'b0;
        else pend_ack = !(eng_byte == 8'hC0 && c0_seen == 0);
        if (mode == 2 && eng_byte == 8'hC0) c0_seen++;
        outst = 1;
        cnt   = 10;
      end
    end
  end

  int         base;
  int         d0;
  int         k0;
  int         g0;
  logic [9:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_len"}, nb - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < nb)
        chk($sformatf("%s_b%0d", tag, i), {22'd0, log_q[base+i]},
            {22'd0, exp_q[i]});
  endtask

  task automatic mark();
    base = nb;
    d0   = done_cnt;
    k0   = nack_cnt;
    g0   = gap_bad;
  endtask

  task automatic pulse();
    @(negedge clk) update_req = 1'b1;
    @(negedge clk) update_req = 1'b0;
  endtask

  task automatic wait_dones(input int n);
    int k = 0;
    while (done_cnt - d0 < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("wait_done", done_cnt - d0 >= n, 1);
  endtask

  task automatic wait_nack();
    int k = 0;
    while (nack_cnt - k0 < 1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("wait_nack", nack_cnt - k0 >= 1, 1);
  endtask

  task automatic wait_bytes(input int n);
    int k = 0;
    while (nb - base < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("wait_bytes", nb - base >= n, 1);
  endtask

  initial begin
    rst        = 1'b1;
    update_req = 1'b0;
    seg_data   = '0;
    bright     = '0;
    disp_on    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_start", eng_start, 0);
    chk("rst_byte", eng_byte, 8'h00);
    chk("rst_fl", {eng_first, eng_last}, 0);
    chk("rst_dn", {done, nack_err}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // basic refresh, display on
    seg_data = 32'h4F5B063F;
    bright   = 3'd3;
    disp_on  = 1'b1;
    mark();
    @(negedge clk) update_req = 1'b1;
    @(negedge clk) update_req = 1'b0;
    chk("lat_busy", busy, 1);
    chk("lat_start", eng_start, 1);
    chk("lat_byte", eng_byte, 8'h40);
    wait_dones(1);
    repeat (20) @(negedge clk);
    exp_q = '{10'h340, 10'h2C0, 10'h03F, 10'h006,
              10'h05B, 10'h14F, 10'h38B};
    check_log("t1");
    chk("t1_done", done_cnt - d0, 1);
    chk("t1_nack", nack_cnt - k0, 0);
    chk("t1_busy", busy, 0);
    chk("t1_gap", gap_bad - g0, 0);

    // display off: brightness ignored
    bright  = 3'd5;
    disp_on = 1'b0;
    mark();
    pulse();
    wait_dones(1);
    repeat (20) @(negedge clk);
    exp_q = '{10'h340, 10'h2C0, 10'h03F, 10'h006,
              10'h05B, 10'h14F, 10'h380};
    check_log("t2");

    // single NACK on address byte, recovered by retry
    bright  = 3'd3;
    disp_on = 1'b1;
    mode    = 2;
    mark();
    pulse();
    wait_dones(1);
    repeat (20) @(negedge clk);
    exp_q = '{10'h340, 10'h2C0, 10'h2C0, 10'h03F, 10'h006,
              10'h05B, 10'h14F, 10'h38B};
    check_log("t3");
    chk("t3_done", done_cnt - d0, 1);
    chk("t3_nack", nack_cnt - k0, 0);
    chk("t3_gap", gap_bad - g0, 0);

    // permanent NACK: two retries then abort
    mode = 1;
    mark();
    pulse();
    wait_nack();
    repeat (100) @(negedge clk);
    exp_q = '{10'h340, 10'h340, 10'h340};
    check_log("t4");
    chk("t4_nack", nack_cnt - k0, 1);
    chk("t4_done", done_cnt - d0, 0);
    chk("t4_busy", busy, 0);

    // requests merged while busy, fresh snapshot on re-run
    mode     = 0;
    seg_data = 32'h11223344;
    mark();
    pulse();
    wait_bytes(3);
    seg_data = 32'h55667788;
    pulse();
    pulse();
    pulse();
    wait_dones(2);
    repeat (40) @(negedge clk);
    exp_q = '{10'h340, 10'h2C0, 10'h044, 10'h033, 10'h022,
              10'h111, 10'h38B,
              10'h340, 10'h2C0, 10'h088, 10'h077, 10'h066,
              10'h155, 10'h38B};
    check_log("t5");
    chk("t5_done", done_cnt - d0, 2);
    chk("t5_busy", busy, 0);

    // reset in the middle of the digit bytes
    seg_data = 32'hA1B2C3D4;
    mark();
    pulse();
    wait_bytes(4);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_busy", busy, 0);
    chk("t6_start", eng_start, 0);
    chk("t6_byte", eng_byte, 8'h00);
    chk("t6_fl", {eng_first, eng_last}, 0);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("t6_quiet", nb - base, 4);
    chk("t6_busy2", busy, 0);
    chk("t6_dn", done_cnt - d0, 0);

    chk("no_both", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
